// File: rtl/mem_arbiter_if.sv
// Signal bundle between the IFU/LSU clients, the memory port and mem_arbiter.
// The arbiter takes the slave view; the clients plus memory model take the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  ifu_req_i;
    logic [ADDR_W-1:0]     ifu_addr_i;
    logic                  ifu_gnt_o;
    logic                  ifu_rvalid_o;
    logic [DATA_W-1:0]     ifu_rdata_o;
    logic                  ifu_err_o;

    logic                  lsu_req_i;
    logic                  lsu_we_i;
    logic [ADDR_W-1:0]     lsu_addr_i;
    logic [DATA_W-1:0]     lsu_wdata_i;
    logic [DATA_W/8-1:0]   lsu_wstrb_i;
    logic                  lsu_gnt_o;
    logic                  lsu_rvalid_o;
    logic [DATA_W-1:0]     lsu_rdata_o;
    logic                  lsu_err_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic [DATA_W/8-1:0]   mem_wstrb_o;
    logic                  mem_ack_i;
    logic [DATA_W-1:0]     mem_rdata_i;

    modport slave (
        input  ifu_req_i, ifu_addr_i,
        output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
        input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wstrb_i,
        output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport master (
        output ifu_req_i, ifu_addr_i,
        input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
        output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wstrb_i,
        input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU fetches and LSU loads/stores,
// one transaction in flight, with a bus-timeout watchdog that turns a missing ack into an error.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    mem_arbiter_if.slave bus
);
    localparam int SW = DATA_W / 8;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic              owner_lsu;
    logic              last_lsu;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [SW-1:0]     cur_wstrb;
    logic [TW-1:0]     timer;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_err;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_err;

    logic              pick_lsu;
    logic              any_req;
    logic              idle;
    logic              timed_out;
    logic              finish;
    logic [DATA_W-1:0] resp_data;

    // On a tie the requester that was not granted last wins; reset leaves IFU as "last".
    assign pick_lsu  = bus.lsu_req_i & (~bus.ifu_req_i | ~last_lsu);
    assign any_req   = bus.ifu_req_i | bus.lsu_req_i;
    assign idle      = rst_n_i & (state == IDLE);
    assign timed_out = (TIMEOUT != 0) && (timer == TLAST);
    assign finish    = bus.mem_ack_i | timed_out;
    assign resp_data = (bus.mem_ack_i & ~cur_we) ? bus.mem_rdata_i : '0;

    assign bus.ifu_gnt_o    = idle & bus.ifu_req_i & ~pick_lsu;
    assign bus.lsu_gnt_o    = idle & pick_lsu;
    assign bus.ifu_rvalid_o = (state == RESP) & ~owner_lsu;
    assign bus.lsu_rvalid_o = (state == RESP) & owner_lsu;
    assign bus.ifu_rdata_o  = ifu_rdata;
    assign bus.ifu_err_o    = ifu_err;
    assign bus.lsu_rdata_o  = lsu_rdata;
    assign bus.lsu_err_o    = lsu_err;

    assign bus.mem_req_o   = (state == BUSY);
    assign bus.mem_we_o    = cur_we;
    assign bus.mem_addr_o  = cur_addr;
    assign bus.mem_wdata_o = cur_wdata;
    assign bus.mem_wstrb_o = cur_wstrb;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            owner_lsu <= 1'b0;
            last_lsu  <= 1'b0;
            cur_we    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            cur_wstrb <= '0;
            timer     <= '0;
            ifu_rdata <= '0;
            ifu_err   <= 1'b0;
            lsu_rdata <= '0;
            lsu_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_lsu <= pick_lsu;
                        last_lsu  <= pick_lsu;
                        cur_we    <= pick_lsu & bus.lsu_we_i;
                        cur_addr  <= pick_lsu ? bus.lsu_addr_i : bus.ifu_addr_i;
                        cur_wdata <= pick_lsu ? bus.lsu_wdata_i : '0;
                        cur_wstrb <= (pick_lsu & bus.lsu_we_i) ? bus.lsu_wstrb_i : '0;
                        timer     <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack arriving on the watchdog's last cycle still counts as success.
                    if (finish) begin
                        if (owner_lsu) begin
                            lsu_rdata <= resp_data;
                            lsu_err   <= ~bus.mem_ack_i;
                        end else begin
                            ifu_rdata <= resp_data;
                            ifu_err   <= ~bus.mem_ack_i;
                        end
                        state <= RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checks dut_a every cycle,
// while dut_b (TIMEOUT=4) exercises the watchdog with literal expectations.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO_A = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO_A)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .bus(a)
    );
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .bus(b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model for dut_a: acks after ack_wait idle BUSY cycles; spurious acks when not requested.
    int          ack_wait = 0;
    logic [31:0] mem_data = '0;
    bit          spurious = 1'b0;
    int          busy_cnt = 0;
    always @(negedge clk) begin
        if (a.mem_req_o) begin
            a.mem_ack_i   = (busy_cnt == ack_wait);
            a.mem_rdata_i = mem_data;
            busy_cnt++;
        end else begin
            busy_cnt      = 0;
            a.mem_ack_i   = spurious;
            a.mem_rdata_i = 32'h5A5A_5A5A;
        end
    end

    bit          m_busy, m_resp, m_lsu_owner, m_last_lsu, m_we;
    logic [31:0] m_addr, m_wdata, m_ifu_rd, m_lsu_rd;
    logic [3:0]  m_wstrb;
    bit          m_ifu_err, m_lsu_err;
    int          m_age;
    bit          want_i, want_l, lsu_wins, m_idle;

    // Every cycle: predict dut_a outputs from the transaction state, compare, then advance.
    always begin
        @(negedge clk);
        #3;
        if (!rst_n) begin
            m_busy = 0; m_resp = 0; m_last_lsu = 0; m_lsu_owner = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_wstrb = '0;
            m_ifu_rd = '0; m_lsu_rd = '0; m_ifu_err = 0; m_lsu_err = 0;
            check_output("rst_ifu_gnt", a.ifu_gnt_o, 0);
            check_output("rst_lsu_gnt", a.lsu_gnt_o, 0);
            check_output("rst_mem_req", a.mem_req_o, 0);
            check_output("rst_mem_we", a.mem_we_o, 0);
            check_output("rst_mem_addr", a.mem_addr_o, 0);
            check_output("rst_mem_wstrb", a.mem_wstrb_o, 0);
            check_output("rst_rvalid", {a.ifu_rvalid_o, a.lsu_rvalid_o}, 0);
            check_output("rst_rdata", {a.ifu_rdata_o, a.lsu_rdata_o}, 0);
            check_output("rst_err", {a.ifu_err_o, a.lsu_err_o}, 0);
        end else begin
            want_i   = a.ifu_req_i;
            want_l   = a.lsu_req_i;
            m_idle   = !m_busy && !m_resp;
            lsu_wins = (want_i && want_l) ? !m_last_lsu : want_l;
            check_output("ifu_gnt", a.ifu_gnt_o, m_idle && want_i && !lsu_wins);
            check_output("lsu_gnt", a.lsu_gnt_o, m_idle && lsu_wins);
            check_output("mem_req", a.mem_req_o, m_busy);
            if (m_busy) begin
                check_output("mem_we", a.mem_we_o, m_we);
                check_output("mem_addr", a.mem_addr_o, m_addr);
                check_output("mem_wdata", a.mem_wdata_o, m_wdata);
                check_output("mem_wstrb", a.mem_wstrb_o, m_wstrb);
            end
            check_output("ifu_rvalid", a.ifu_rvalid_o, m_resp && !m_lsu_owner);
            check_output("lsu_rvalid", a.lsu_rvalid_o, m_resp && m_lsu_owner);
            check_output("ifu_rdata", a.ifu_rdata_o, m_ifu_rd);
            check_output("ifu_err", a.ifu_err_o, m_ifu_err);
            check_output("lsu_rdata", a.lsu_rdata_o, m_lsu_rd);
            check_output("lsu_err", a.lsu_err_o, m_lsu_err);

            if (m_resp) begin
                m_resp = 0;
            end else if (m_busy) begin
                if (a.mem_ack_i || (TO_A != 0 && m_age == TO_A - 1)) begin
                    if (m_lsu_owner) begin
                        m_lsu_rd  = (a.mem_ack_i && !m_we) ? a.mem_rdata_i : 32'h0;
                        m_lsu_err = !a.mem_ack_i;
                    end else begin
                        m_ifu_rd  = a.mem_ack_i ? a.mem_rdata_i : 32'h0;
                        m_ifu_err = !a.mem_ack_i;
                    end
                    m_busy = 0;
                    m_resp = 1;
                end else begin
                    m_age++;
                end
            end else if (want_i || want_l) begin
                m_lsu_owner = lsu_wins;
                m_last_lsu  = lsu_wins;
                m_we        = lsu_wins && a.lsu_we_i;
                m_addr      = lsu_wins ? a.lsu_addr_i : a.ifu_addr_i;
                m_wdata     = lsu_wins ? a.lsu_wdata_i : 32'h0;
                m_wstrb     = m_we ? a.lsu_wstrb_i : 4'h0;
                m_busy      = 1;
                m_age       = 0;
            end
        end
    end

    // Called right after a negedge with the request already driven; drops it once granted.
    task automatic wait_grant(input bit is_lsu, output int at, output bit other);
        at = -1;
        other = 0;
        for (int i = 0; i < 50; i++) begin
            #2;
            if (is_lsu ? a.lsu_gnt_o : a.ifu_gnt_o) begin
                at = cyc;
                other = is_lsu ? a.ifu_gnt_o : a.lsu_gnt_o;
                @(negedge clk);
                if (is_lsu) a.lsu_req_i = 0;
                else        a.ifu_req_i = 0;
                return;
            end
            @(negedge clk);
        end
        check_output(is_lsu ? "lsu_gnt_timeout" : "ifu_gnt_timeout", 0, 1);
    endtask

    task automatic wait_rvalid(input bit is_lsu, output int at);
        at = -1;
        for (int i = 0; i < 50; i++) begin
            #2;
            if (is_lsu ? a.lsu_rvalid_o : a.ifu_rvalid_o) begin
                at = cyc;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        check_output(is_lsu ? "lsu_rvalid_timeout" : "ifu_rvalid_timeout", 0, 1);
    endtask

    task automatic apply_stimulus(input bit ifu, input logic [31:0] iaddr, input bit lsu, input bit we,
                                  input logic [31:0] laddr, input logic [31:0] wdata, input logic [3:0] wstrb);
        @(negedge clk);
        a.ifu_req_i   = ifu;
        a.ifu_addr_i  = iaddr;
        a.lsu_req_i   = lsu;
        a.lsu_we_i    = we;
        a.lsu_addr_i  = laddr;
        a.lsu_wdata_i = wdata;
        a.lsu_wstrb_i = wstrb;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  g1, g2, g3, r1, cnt;
        bit  oth, seen;
        a.ifu_req_i = 0; a.ifu_addr_i = '0; a.lsu_req_i = 0; a.lsu_we_i = 0;
        a.lsu_addr_i = '0; a.lsu_wdata_i = '0; a.lsu_wstrb_i = '0;
        a.mem_ack_i = 0; a.mem_rdata_i = '0;
        b.ifu_req_i = 0; b.ifu_addr_i = '0; b.lsu_req_i = 0; b.lsu_we_i = 0;
        b.lsu_addr_i = '0; b.lsu_wdata_i = '0; b.lsu_wstrb_i = '0;
        b.mem_ack_i = 0; b.mem_rdata_i = 32'hFFFF_FFFF;

        // Requests during reset must not be granted.
        repeat (2) @(negedge clk);
        a.ifu_req_i = 1;
        #2 check_output("t0_gnt_in_reset", a.ifu_gnt_o, 0);
        @(negedge clk);
        a.ifu_req_i = 0;
        @(negedge clk);
        rst_n = 1;

        // Tie after reset: LSU, then IFU back-to-back, then tie again goes to LSU.
        ack_wait = 0;
        mem_data = 32'h1111_2222;
        apply_stimulus(1, 32'h8000_0004, 1, 0, 32'h8000_0200, 32'h0, 4'h0);
        #2;
        g1 = cyc;
        check_output("t2_first_lsu_gnt", a.lsu_gnt_o, 1);
        check_output("t2_first_ifu_gnt", a.ifu_gnt_o, 0);
        @(negedge clk);
        a.lsu_req_i = 0;
        mem_data = 32'h3333_4444;
        wait_grant(0, g2, oth);
        check_output("t2_ifu_gnt_cycle", g2 - g1, 3);
        a.lsu_req_i = 1; a.lsu_addr_i = 32'h8000_0204;
        a.ifu_req_i = 1; a.ifu_addr_i = 32'h8000_000C;
        wait_grant(1, g3, oth);
        check_output("t2_tie_again_ifu_gnt", oth, 0);
        wait_grant(0, g2, oth);
        wait_rvalid(0, r1);
        check_output("t2_lsu_rdata", a.lsu_rdata_o, 32'h3333_4444);

        // IFU alone: minimum latency.
        mem_data = 32'h0000_0297;
        apply_stimulus(1, 32'h8000_0000, 0, 0, 32'h0, 32'h0, 4'h0);
        wait_grant(0, g1, oth);
        wait_rvalid(0, r1);
        check_output("t1_latency", r1 - g1, 2);
        check_output("t1_ifu_rdata", a.ifu_rdata_o, 32'h0000_0297);
        check_output("t1_ifu_err", a.ifu_err_o, 0);

        // LSU byte write, slow ack; load data must read back as zero.
        ack_wait = 5;
        mem_data = 32'hCAFE_F00D;
        apply_stimulus(0, 32'h0, 1, 1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011);
        wait_grant(1, g1, oth);
        #2;
        check_output("t3_mem_req", a.mem_req_o, 1);
        check_output("t3_mem_we", a.mem_we_o, 1);
        check_output("t3_mem_wstrb", a.mem_wstrb_o, 4'b0011);
        check_output("t3_mem_addr", a.mem_addr_o, 32'h8000_0100);
        check_output("t3_mem_wdata", a.mem_wdata_o, 32'hDEAD_BEEF);
        @(negedge clk);
        a.lsu_we_i = 0;
        wait_rvalid(1, r1);
        check_output("t3_latency", r1 - g1, 7);
        check_output("t3_lsu_rdata", a.lsu_rdata_o, 0);
        check_output("t3_lsu_err", a.lsu_err_o, 0);

        // Spurious acks in IDLE and RESP are ignored.
        spurious = 1;
        ack_wait = 1;
        mem_data = 32'h0000_0013;
        repeat (3) @(negedge clk);
        apply_stimulus(1, 32'h8000_0008, 0, 0, 32'h0, 32'h0, 4'h0);
        wait_grant(0, g1, oth);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (a.ifu_rvalid_o || a.lsu_rvalid_o) cnt++;
            @(negedge clk);
        end
        check_output("t6_rvalid_count", cnt, 1);
        check_output("t6_ifu_rdata", a.ifu_rdata_o, 32'h0000_0013);
        spurious = 0;

        // Reset while BUSY with an LSU owner: abort, then the LSU-first tie rule returns.
        ack_wait = 20;
        apply_stimulus(0, 32'h0, 1, 0, 32'h8000_0300, 32'h0, 4'h0);
        wait_grant(1, g1, oth);
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        check_output("t5_mem_req_async", a.mem_req_o, 0);
        check_output("t5_lsu_rdata_cleared", a.lsu_rdata_o, 0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2 if (a.ifu_rvalid_o || a.lsu_rvalid_o) cnt++;
        end
        check_output("t5_no_rvalid", cnt, 0);
        ack_wait = 0;
        @(negedge clk);
        rst_n = 1;
        a.ifu_req_i = 1; a.ifu_addr_i = 32'h8000_0010;
        a.lsu_req_i = 1; a.lsu_addr_i = 32'h8000_0304;
        #2;
        check_output("t5_tie_lsu_gnt", a.lsu_gnt_o, 1);
        check_output("t5_tie_ifu_gnt", a.ifu_gnt_o, 0);
        @(negedge clk);
        a.lsu_req_i = 0;
        wait_grant(0, g1, oth);
        wait_rvalid(0, r1);

        // dut_b watchdog: no ack ever, request held exactly TIMEOUT cycles.
        @(negedge clk);
        b.lsu_req_i = 1;
        b.lsu_addr_i = 32'h8000_0400;
        #2 check_output("t4_gnt", b.lsu_gnt_o, 1);
        @(negedge clk);
        b.lsu_req_i = 0;
        cnt = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (b.mem_req_o) cnt++;
            if (b.lsu_rvalid_o) begin
                seen = 1;
                check_output("t4_err", b.lsu_err_o, 1);
                check_output("t4_rdata", b.lsu_rdata_o, 0);
                break;
            end
            @(negedge clk);
        end
        check_output("t4_rvalid_seen", seen, 1);
        check_output("t4_req_cycles", cnt, 4);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
